// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and opcode constants for the 3BC multi-cycle control unit.
package multicycle_ctrl_pkg;

    localparam logic [3:0] kSTR = 4'b0111;
    localparam logic [3:0] kLDR = 4'b1100;
    localparam logic [3:0] kLDI = 4'b1101;
    localparam logic [3:0] kBR  = 4'b1110;
    localparam logic [3:0] kNOP = 4'b1111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } ctrl_state_t;

    typedef enum logic [1:0] {
        LD_IMM = 2'b00,
        LD_MEM = 2'b01,
        LD_ALU = 2'b10
    } reg_load_t;

    typedef struct packed {
        logic alu;
        logic ldi;
        logic ldr;
        logic str;
        logic br;
        logic nop;
        logic halt;
    } instr_class_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= 4'd6) || ((op >= 4'd8) && (op <= 4'd11));
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational one-hot classification of the latched instruction register.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int IW  = 9,
    parameter int OPW = 4
) (
    input  logic [IW-1:0] ir_i,
    output instr_class_t  cls_o
);

    logic [OPW-1:0] opcode_s;
    instr_class_t   cls_s;

    assign opcode_s = ir_i[IW-1 -: OPW];

    // HALT is the all-ones word and takes priority over the NOP opcode class
    always_comb begin
        cls_s = '0;
        if (&ir_i) begin
            cls_s.halt = 1'b1;
        end else begin
            case (opcode_s)
                kSTR:    cls_s.str = 1'b1;
                kLDR:    cls_s.ldr = 1'b1;
                kLDI:    cls_s.ldi = 1'b1;
                kBR:     cls_s.br  = 1'b1;
                kNOP:    cls_s.nop = 1'b1;
                default: cls_s.alu = is_alu_op(opcode_s);
            endcase
        end
    end

    assign cls_o = cls_s;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 3BC processor (FETCH/DECODE/EXEC/MEM/WB).
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int IW      = 9,
    parameter int OPW     = 4,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] Instruction,
    input  logic          Zero,
    output logic          PcEn,
    output logic          Jump,
    output logic          RegWrEn,
    output logic [1:0]    RegLoadType,
    output logic          MemRdEn,
    output logic          StoreInst,
    output logic          Busy,
    output logic          Ack
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] InstrCount
`endif
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    if (MEM_LAT < 1) begin : g_bad_mem_lat
        $error("multicycle_ctrl: MEM_LAT must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multicycle_ctrl: CNT_W must be at least 1");
    end

    ctrl_state_t      state_q;
    logic [IW-1:0]    ir_q;
    logic [LAT_W-1:0] lat_q;
    instr_class_t     cls_s;

    logic      pc_en_q;
    logic      br_q;
    logic      reg_wr_q;
    reg_load_t load_q;
    logic      mem_rd_q;
    logic      store_q;
    logic      busy_q;
    logic      ack_q;

    multicycle_ctrl_decode #(
        .IW  (IW),
        .OPW (OPW)
    ) u_ctrl_decode (
        .ir_i  (ir_q),
        .cls_o (cls_s)
    );

    // State sequencing; each output register is loaded with the value for the state being entered
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            ir_q     <= '0;
            lat_q    <= '0;
            pc_en_q  <= 1'b0;
            br_q     <= 1'b0;
            reg_wr_q <= 1'b0;
            load_q   <= LD_ALU;
            mem_rd_q <= 1'b0;
            store_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            pc_en_q  <= 1'b0;
            br_q     <= 1'b0;
            reg_wr_q <= 1'b0;
            load_q   <= LD_ALU;
            mem_rd_q <= 1'b0;
            store_q  <= 1'b0;
            busy_q   <= 1'b1;
            ack_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                FETCH: begin
                    ir_q    <= Instruction;
                    state_q <= DECODE;
                end
                DECODE: begin
                    lat_q <= '0;
                    if (cls_s.halt) begin
                        state_q <= HALT;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                    end else if (cls_s.ldr) begin
                        state_q  <= MEM;
                        mem_rd_q <= 1'b1;
                    end else if (cls_s.str) begin
                        state_q <= MEM;
                        store_q <= 1'b1;
                        pc_en_q <= 1'b1;
                    end else begin
                        state_q  <= EXEC;
                        pc_en_q  <= cls_s.alu | cls_s.ldi | cls_s.br | cls_s.nop;
                        reg_wr_q <= cls_s.alu | cls_s.ldi;
                        load_q   <= cls_s.ldi ? LD_IMM : LD_ALU;
                        br_q     <= cls_s.br;
                    end
                end
                EXEC: begin
                    state_q <= FETCH;
                end
                MEM: begin
                    if (cls_s.ldr && (lat_q != LAT_LAST)) begin
                        state_q  <= MEM;
                        lat_q    <= lat_q + LAT_W'(1);
                        mem_rd_q <= 1'b1;
                    end else if (cls_s.ldr) begin
                        state_q  <= WB;
                        lat_q    <= '0;
                        reg_wr_q <= 1'b1;
                        load_q   <= LD_MEM;
                        pc_en_q  <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                WB: begin
                    state_q <= FETCH;
                end
                HALT: begin
                    busy_q <= 1'b0;
                    if (Start) begin
                        state_q <= HALT;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Zero is only valid during the branch's EXEC cycle, so Jump samples it live
    assign Jump        = br_q & Zero;
    assign PcEn        = pc_en_q;
    assign RegWrEn     = reg_wr_q;
    assign RegLoadType = load_q;
    assign MemRdEn     = mem_rd_q;
    assign StoreInst   = store_q;
    assign Busy        = busy_q;
    assign Ack         = ack_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q;
    logic [CNT_W-1:0] instr_cnt_d;
    logic             start_clr_s;
    logic             halt_entry_s;

    // Saturating counters, cleared when a new program run leaves IDLE
    always_comb begin
        start_clr_s  = (state_q == IDLE) && Start;
        halt_entry_s = (state_q == DECODE) && cls_s.halt;
        cycle_cnt_d  = cycle_cnt_q;
        instr_cnt_d  = instr_cnt_q;
        if (start_clr_s) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else begin
            if (busy_q && !(&cycle_cnt_q)) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end else begin
                cycle_cnt_d = cycle_cnt_q;
            end
            if ((pc_en_q || halt_entry_s) && !(&instr_cnt_q)) begin
                instr_cnt_d = instr_cnt_q + CNT_W'(1);
            end else begin
                instr_cnt_d = instr_cnt_q;
            end
        end
    end

    // Counter state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign CycleCount = cycle_cnt_q;
    assign InstrCount = instr_cnt_q;
`endif

endmodule
